hs_link_arbiter: RTL

HS_LINK_ARBITER -- requirements
Module: hs_link_arbiter

---
 rtl/hs_link_pkg.sv | 18 +
 rtl/hs_link_arbiter_rr_picker.sv | 46 ++++
 rtl/hs_link_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hs_link_pkg.sv
// Shared types and default constants for the four-phase link arbiter.
package hs_link_pkg;

    localparam int DEF_NREQ    = 4;
    localparam int DEF_DW      = 4;
    localparam int DEF_TIMEOUT = 15;
    localparam int STATE_W     = 3;
    localparam int WD_W        = 8;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_SEND    = 3'd1,
        S_RELEASE = 3'd2,
        S_DONE    = 3'd3,
        S_ABORT   = 3'd4
    } state_e;

endpackage

// File: rtl/hs_link_arbiter_rr_picker.sv
// Combinational round-robin search: first asserted req at or above ptr, wrapping to 0.
module rr_picker
    import hs_link_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   index
);

    logic [PW-1:0] cand_s;
    logic          found_s;

    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end else begin
            sum = sum;
        end
        return PW'(sum);
    endfunction

    // Walk the requesters in priority order starting at ptr; keep the first hit.
    always_comb begin
        grant   = '0;
        index   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = wrap_idx(ptr, i);
            if (!found_s && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                index         = cand_s;
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/hs_link_arbiter.sv
// Round-robin arbiter granting one requester at a time onto a four-phase send/ack link.
// Optional watchdog abort is enabled by defining HS_LINK_ARB_TIMEOUT_EN.
module hs_link_arbiter
    import hs_link_pkg::*;
#(
    parameter int NREQ    = DEF_NREQ,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic [NREQ-1:0]    err,
    output logic               send,
    output logic [DW-1:0]      data_out,
    input  logic               ack,
    output logic               busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_r, state_s;
    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   win_r;
    logic [PW-1:0]   nxt_ptr_s;
    logic [NREQ-1:0] pick_gnt_s;
    logic [PW-1:0]   pick_idx_s;
    logic [DW-1:0]   sel_data_s;
    logic [NREQ-1:0] gnt_r;
    logic [NREQ-1:0] done_r;
    logic            send_r;
    logic            busy_r;
    logic [DW-1:0]   data_r;
    logic            wd_expired_s;

    rr_picker #(.NREQ(NREQ), .PW(PW)) u_picker (
        .req   (req),
        .ptr   (ptr_r),
        .grant (pick_gnt_s),
        .index (pick_idx_s)
    );

    // Payload mux steered by the one-hot pick.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_data_s = sel_data_s | (req_data[i*DW +: DW] & {DW{pick_gnt_s[i]}});
        end
    end

    // Pointer moves just past the requester that was served or aborted.
    always_comb begin
        if (win_r == PW'(NREQ - 1)) begin
            nxt_ptr_s = '0;
        end else begin
            nxt_ptr_s = win_r + PW'(1);
        end
    end

`ifdef HS_LINK_ARB_TIMEOUT_EN
    logic [WD_W-1:0] wd_r;
    logic [NREQ-1:0] err_r;

    assign wd_expired_s = (wd_r >= WD_W'(TIMEOUT - 1));

    // Watchdog: zero on entry to SEND/RELEASE, counts each cycle spent there.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_r <= '0;
        end else if ((state_s != state_r) && ((state_s == S_SEND) || (state_s == S_RELEASE))) begin
            wd_r <= '0;
        end else if ((state_r == S_SEND) || (state_r == S_RELEASE)) begin
            wd_r <= wd_r + WD_W'(1);
        end else begin
            wd_r <= '0;
        end
    end

    // Abort pulse goes to the current grant holder.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= '0;
        end else if (state_s == S_ABORT) begin
            err_r <= gnt_r;
        end else begin
            err_r <= '0;
        end
    end

    assign err = err_r;
`else
    assign wd_expired_s = 1'b0;
    assign err          = '0;
`endif

    // Next-state logic; ack progress always wins over an expiring watchdog.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if ((|req) && !ack) begin
                    state_s = S_SEND;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SEND: begin
                if (ack) begin
                    state_s = S_RELEASE;
                end else if (wd_expired_s) begin
                    state_s = S_ABORT;
                end else begin
                    state_s = S_SEND;
                end
            end
            S_RELEASE: begin
                if (!ack) begin
                    state_s = S_DONE;
                end else if (wd_expired_s) begin
                    state_s = S_ABORT;
                end else begin
                    state_s = S_RELEASE;
                end
            end
            S_DONE:  state_s = S_IDLE;
            S_ABORT: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State, pointer and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            ptr_r   <= '0;
            win_r   <= '0;
            gnt_r   <= '0;
            done_r  <= '0;
            send_r  <= 1'b0;
            busy_r  <= 1'b0;
            data_r  <= '0;
        end else begin
            state_r <= state_s;
            send_r  <= (state_s == S_SEND);
            busy_r  <= (state_s != S_IDLE);
            done_r  <= (state_s == S_DONE) ? gnt_r : '0;
            if ((state_r == S_IDLE) && (state_s == S_SEND)) begin
                gnt_r  <= pick_gnt_s;
                win_r  <= pick_idx_s;
                data_r <= sel_data_s;
            end else if (state_s == S_IDLE) begin
                gnt_r <= '0;
            end else begin
                gnt_r <= gnt_r;
            end
            if ((state_s == S_DONE) || (state_s == S_ABORT)) begin
                ptr_r <= nxt_ptr_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign gnt      = gnt_r;
    assign done     = done_r;
    assign send     = send_r;
    assign busy     = busy_r;
    assign data_out = data_r;

endmodule
